// File: rtl/gas_station_pkg.sv
// Shared constants for the gas station pump meter: FSM encoding and defaults.
package gas_station_pkg;

  typedef logic [1:0] meter_state_t;

  // Kept as plain constants so legacy tools that read METER_STATE see fixed codes
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PUMPING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int         DEF_VOL_W      = 12;
  localparam int         DEF_COST_W     = 16;
  localparam logic [7:0] DEF_PRICE_UNL  = 8'd3;
  localparam logic [7:0] DEF_PRICE_PREM = 8'd4;

endpackage

// File: rtl/meter_accum.sv
// Volume/cost accumulator with the end-of-sale limit and overflow compare.
module meter_accum #(
  parameter int VOL_W  = 12,
  parameter int COST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [7:0]        price_i,
  input  logic [COST_W-1:0] prepaid_i,
  output logic [VOL_W-1:0]  volume_o,
  output logic [COST_W-1:0] cost_o,
  output logic              limit_hit_o
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic [COST_W+1:0] cost_after2;

  // Volume/cost after accepting the pulse being offered this cycle
  assign vol_d  = vol_q + VOL_W'(1);
  assign cost_d = cost_q + COST_W'(price_i);

  // New cost plus one more price: decides whether another pulse could be sold.
  // Two extra bits so the sum can never wrap while it is compared.
  assign cost_after2 = (COST_W+2)'(cost_q) + (COST_W+2)'({price_i, 1'b0});

  // Sale must end after this pulse: volume saturates, credit exhausted, or cost would overflow
  assign limit_hit_o = (vol_d == VOL_MAX)
                    || ((prepaid_i != '0) && (cost_after2 > (COST_W+2)'(prepaid_i)))
                    || (cost_after2[COST_W+1:COST_W] != 2'b00);

  // Counters clear on sale start and step once per accepted flow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q  <= '0;
      cost_q <= '0;
    end else if (clr_i) begin
      vol_q  <= '0;
      cost_q <= '0;
    end else if (add_i) begin
      vol_q  <= vol_d;
      cost_q <= cost_d;
    end
  end

  assign volume_o = vol_q;
  assign cost_o   = cost_q;

endmodule

// File: rtl/gas_pump_meter.sv
// Pump meter: runs the pump during a delivery, meters fuel, and signals TANKFULL.
module gas_pump_meter
  import gas_station_pkg::*;
#(
  parameter int         VOL_W      = DEF_VOL_W,
  parameter int         COST_W     = DEF_COST_W,
  parameter logic [7:0] PRICE_UNL  = DEF_PRICE_UNL,
  parameter logic [7:0] PRICE_PREM = DEF_PRICE_PREM
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              DELIVERGAS,
  input  logic              UNLEADED,
  input  logic [COST_W-1:0] PREPAID,
  input  logic              FLOW_PULSE,
  input  logic              TANK_SENSOR,
  input  logic              EMERGENCY_STOP,
  output logic              PUMP_ON,
  output logic              TANKFULL,
  output logic [VOL_W-1:0]  VOLUME,
  output logic [COST_W-1:0] COST,
  output logic              SALE_DONE,
  output logic              ABORTED,
  output logic [1:0]        METER_STATE
);

  meter_state_t      state_q, state_d;
  logic              dg_q;
  logic              aborted_q, aborted_d;
  logic [7:0]        price_q, price_d;
  logic [COST_W-1:0] prepaid_q, prepaid_d;
  logic              acc_clr, acc_add, limit_hit;
  logic              start;
  logic [7:0]        price_sel;

  assign start     = DELIVERGAS && !dg_q;
  assign price_sel = UNLEADED ? PRICE_UNL : PRICE_PREM;

  // Next-state and sale bookkeeping; terminations in PUMPING are priority ordered
  always_comb begin
    state_d   = state_q;
    aborted_d = aborted_q;
    price_d   = price_q;
    prepaid_d = prepaid_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          price_d   = price_sel;
          prepaid_d = PREPAID;
          aborted_d = 1'b0;
          acc_clr   = 1'b1;
          // Credit too small for even one unit: finish without running the pump
          if ((PREPAID != '0) && (PREPAID < COST_W'(price_sel))) state_d = ST_FULL;
          else                                                   state_d = ST_PUMPING;
        end
      end
      ST_PUMPING: begin
        if (EMERGENCY_STOP) begin
          state_d   = ST_FULL;
          aborted_d = 1'b1;
        end else if (!DELIVERGAS) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (TANK_SENSOR) begin
          state_d = ST_FULL;
        end else if (FLOW_PULSE) begin
          acc_add = 1'b1;
          if (limit_hit) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!DELIVERGAS) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; edge detector loads the live level during reset so a
  // command held high across reset is not mistaken for a new start
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dg_q      <= DELIVERGAS;
      aborted_q <= 1'b0;
      price_q   <= '0;
      prepaid_q <= '0;
    end else begin
      state_q   <= state_d;
      dg_q      <= DELIVERGAS;
      aborted_q <= aborted_d;
      price_q   <= price_d;
      prepaid_q <= prepaid_d;
    end
  end

  meter_accum #(.VOL_W(VOL_W), .COST_W(COST_W)) u_accum (
    .clk         (clock),
    .rst         (reset),
    .clr_i       (acc_clr),
    .add_i       (acc_add),
    .price_i     (price_q),
    .prepaid_i   (prepaid_q),
    .volume_o    (VOLUME),
    .cost_o      (COST),
    .limit_hit_o (limit_hit)
  );

  assign PUMP_ON     = (state_q == ST_PUMPING);
  assign TANKFULL    = (state_q == ST_FULL);
  assign SALE_DONE   = (state_q == ST_DONE);
  assign ABORTED     = aborted_q;
  assign METER_STATE = state_q;

endmodule

// File: tb/tb_gas_pump_meter.sv
// Directed bench for gas_pump_meter: walks the six delivery scenarios.
module tb_gas_pump_meter;

  logic        clock = 1'b0;
  logic        reset;
  logic        DELIVERGAS, UNLEADED, FLOW_PULSE, TANK_SENSOR, EMERGENCY_STOP;
  logic [15:0] PREPAID;
  logic        PUMP_ON, TANKFULL, SALE_DONE, ABORTED;
  logic [11:0] VOLUME;
  logic [15:0] COST;
  logic [1:0]  METER_STATE;

  int errors = 0;
  int checks = 0;

  gas_pump_meter dut (
    .clock          (clock),
    .reset          (reset),
    .DELIVERGAS     (DELIVERGAS),
    .UNLEADED       (UNLEADED),
    .PREPAID        (PREPAID),
    .FLOW_PULSE     (FLOW_PULSE),
    .TANK_SENSOR    (TANK_SENSOR),
    .EMERGENCY_STOP (EMERGENCY_STOP),
    .PUMP_ON        (PUMP_ON),
    .TANKFULL       (TANKFULL),
    .VOLUME         (VOLUME),
    .COST           (COST),
    .SALE_DONE      (SALE_DONE),
    .ABORTED        (ABORTED),
    .METER_STATE    (METER_STATE)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle to the falling edge where outputs are sampled
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    FLOW_PULSE = 1'b1; step();
    FLOW_PULSE = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; DELIVERGAS = 1'b0; UNLEADED = 1'b0; PREPAID = '0;
    FLOW_PULSE = 1'b0; TANK_SENSOR = 1'b0; EMERGENCY_STOP = 1'b0;
    @(negedge clock);
    step(); step();
    chk("rst_state", METER_STATE, 0);
    chk("rst_pump", PUMP_ON, 0);
    chk("rst_tankfull", TANKFULL, 0);
    chk("rst_volume", VOLUME, 0);
    chk("rst_cost", COST, 0);
    chk("rst_done", SALE_DONE, 0);
    chk("rst_aborted", ABORTED, 0);
    reset = 1'b0; step();

    // 1: unleaded, prepaid 12 -> 4 units at 3 cents, then limit
    UNLEADED = 1'b1; PREPAID = 16'd12; DELIVERGAS = 1'b1; step();
    chk("t1_state", METER_STATE, 1);
    chk("t1_pump", PUMP_ON, 1);
    for (int i = 0; i < 10; i++) begin
      FLOW_PULSE = 1'b1; step();
      FLOW_PULSE = 1'b0;
      if (i == 3) begin
        chk("t1_tankfull_4th", TANKFULL, 1);
        chk("t1_pump_off_4th", PUMP_ON, 0);
      end
      step();
    end
    chk("t1_volume", VOLUME, 4);
    chk("t1_cost", COST, 12);
    chk("t1_tankfull", TANKFULL, 1);
    DELIVERGAS = 1'b0; step();
    chk("t1_done", SALE_DONE, 1);
    chk("t1_aborted", ABORTED, 0);
    chk("t1_tf_clear", TANKFULL, 0);
    step();
    chk("t1_done_once", SALE_DONE, 0);
    chk("t1_idle", METER_STATE, 0);
    chk("t1_vol_hold", VOLUME, 4);

    // 2: premium, no limit, tank sensor wins over a coincident pulse
    UNLEADED = 1'b0; PREPAID = '0; DELIVERGAS = 1'b1; step();
    chk("t2_vol_clr", VOLUME, 0);
    for (int i = 0; i < 5; i++) pulse();
    TANK_SENSOR = 1'b1; FLOW_PULSE = 1'b1; step();
    TANK_SENSOR = 1'b0; FLOW_PULSE = 1'b0;
    chk("t2_volume", VOLUME, 5);
    chk("t2_cost", COST, 20);
    chk("t2_tankfull", TANKFULL, 1);
    DELIVERGAS = 1'b0; step();
    chk("t2_done", SALE_DONE, 1);
    chk("t2_aborted", ABORTED, 0);
    step();

    // 3: emergency stop after 3 units
    UNLEADED = 1'b1; DELIVERGAS = 1'b1; step();
    for (int i = 0; i < 3; i++) pulse();
    EMERGENCY_STOP = 1'b1; FLOW_PULSE = 1'b1; step();
    EMERGENCY_STOP = 1'b0; FLOW_PULSE = 1'b0;
    chk("t3_pump", PUMP_ON, 0);
    chk("t3_tankfull", TANKFULL, 1);
    chk("t3_volume", VOLUME, 3);
    chk("t3_cost", COST, 9);
    DELIVERGAS = 1'b0; step();
    chk("t3_done", SALE_DONE, 1);
    chk("t3_aborted", ABORTED, 1);
    step();

    // 4: controller drops DELIVERGAS after 2 units
    DELIVERGAS = 1'b1; step();
    chk("t4_abort_clr", ABORTED, 0);
    pulse(); pulse();
    DELIVERGAS = 1'b0; step();
    chk("t4_state", METER_STATE, 3);
    chk("t4_tankfull", TANKFULL, 0);
    chk("t4_done", SALE_DONE, 1);
    chk("t4_aborted", ABORTED, 1);
    chk("t4_volume", VOLUME, 2);
    step();
    chk("t4_idle", METER_STATE, 0);
    chk("t4_abort_hold", ABORTED, 1);

    // 5: prepaid below one unit -> straight to FULL
    UNLEADED = 1'b1; PREPAID = 16'd2; DELIVERGAS = 1'b1; step();
    chk("t5_state", METER_STATE, 2);
    chk("t5_pump", PUMP_ON, 0);
    chk("t5_tankfull", TANKFULL, 1);
    pulse();
    chk("t5_volume", VOLUME, 0);
    DELIVERGAS = 1'b0; step();
    chk("t5_done", SALE_DONE, 1);
    step();

    // 6: reset mid-sale, held DELIVERGAS is not a restart
    PREPAID = '0; DELIVERGAS = 1'b1; step();
    for (int i = 0; i < 7; i++) pulse();
    chk("t6_volume7", VOLUME, 7);
    reset = 1'b1; FLOW_PULSE = 1'b1; step();
    FLOW_PULSE = 1'b0;
    chk("t6_rst_state", METER_STATE, 0);
    chk("t6_rst_pump", PUMP_ON, 0);
    chk("t6_rst_volume", VOLUME, 0);
    chk("t6_rst_cost", COST, 0);
    reset = 1'b0; step(); step();
    chk("t6_no_restart", METER_STATE, 0);
    DELIVERGAS = 1'b0; step();
    DELIVERGAS = 1'b1; step();
    chk("t6_restart", METER_STATE, 1);
    DELIVERGAS = 1'b0; step(); step();
    chk("t6_final_idle", METER_STATE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
